// File: rtl/fpu_to_int_if.sv
//------------------------------------------------------------------------------
// fpu_to_int_if
// Valid/ready bundle between the FPU result port, the float-to-int decoder and
// the integer datapath consumer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fpu_to_int_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_status;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic        out_inexact;

    // Producer of floats / consumer of integers (testbench or surrounding logic)
    modport master (
        output in_valid, in_data, in_status, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_inexact
    );

    // The converter itself
    modport slave (
        input  in_valid, in_data, in_status, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_inexact
    );
endinterface

`default_nettype wire

// File: rtl/fpu_to_int.sv
//------------------------------------------------------------------------------
// fpu_to_int
// Converts the FPU's 1/7/24 custom float plus status into a signed 32-bit
// integer, truncating toward zero, using an iterative SHIFT_STEP-bit shifter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fpu_to_int #(
    parameter int SHIFT_STEP = 1,
    parameter int EXP_BIAS   = 63
) (
    input  logic         clk,
    input  logic         rst,
    fpu_to_int_if.slave  bus,
    output logic         busy
);

    // Exponent thresholds: RIGHT for [RIGHT_LO, LEFT_LO), LEFT for [LEFT_LO, SAT_LO)
    localparam logic [31:0] C_RIGHT_LO = 32'(EXP_BIAS);
    localparam logic [31:0] C_LEFT_LO  = 32'(EXP_BIAS + 24);
    localparam logic [31:0] C_SAT_LO   = 32'(EXP_BIAS + 31);
    localparam logic [31:0] C_EXP_MAX  = 32'd127;
    localparam logic [4:0]  C_STEP     = 5'(SHIFT_STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic        sign_q;
    logic        dir_left_q;
    logic        sat_q;
    logic        small_q;
    logic        sticky_q;
    logic        stat_inx_q;
    logic [31:0] mag_q;
    logic [4:0]  rem_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic        out_sat_q;
    logic        out_inexact_q;

    // Input classification (only meaningful in IDLE when a float is offered)
    logic [31:0] exp_w;
    logic        cls_zero_w;
    logic        cls_sat_w;
    logic        cls_small_w;
    logic        cls_left_w;
    logic [4:0]  rem_right_w;
    logic [4:0]  rem_left_w;

    assign exp_w       = {25'd0, bus.in_data[30:24]};
    assign cls_zero_w  = (exp_w == 32'd0) || bus.in_status[2];
    assign cls_sat_w   = (exp_w == C_EXP_MAX) || bus.in_status[1] || (exp_w >= C_SAT_LO);
    assign cls_small_w = (exp_w < C_RIGHT_LO);
    assign cls_left_w  = (exp_w >= C_LEFT_LO);
    assign rem_right_w = 5'(C_LEFT_LO - exp_w);
    assign rem_left_w  = 5'(exp_w - C_LEFT_LO);

    // One shifter step: never move more bits than remain
    logic [4:0]  step_k;
    logic [31:0] mag_right_d;
    logic [31:0] mag_left_d;
    logic [31:0] lost_bits;
    logic [4:0]  rem_d;

    assign step_k      = (rem_q < C_STEP) ? rem_q : C_STEP;
    assign mag_right_d = mag_q >> step_k;
    assign mag_left_d  = mag_q << step_k;
    assign lost_bits   = mag_q & ~(32'hFFFF_FFFF << step_k);
    assign rem_d       = rem_q - step_k;

    // Final integer: saturation constant or two's-complement of the magnitude
    logic [31:0] result_d;
    always_comb begin
        result_d = mag_q;
        if (sat_q) begin
            result_d = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (sign_q) begin
            result_d = ~mag_q + 32'd1;
        end
    end

    // Control FSM with registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sign_q        <= 1'b0;
            dir_left_q    <= 1'b0;
            sat_q         <= 1'b0;
            small_q       <= 1'b0;
            sticky_q      <= 1'b0;
            stat_inx_q    <= 1'b0;
            mag_q         <= 32'd0;
            rem_q         <= 5'd0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 32'd0;
            out_sat_q     <= 1'b0;
            out_inexact_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        sign_q     <= bus.in_data[31];
                        mag_q      <= {7'd0, 1'b1, bus.in_data[23:0]};
                        sticky_q   <= 1'b0;
                        stat_inx_q <= bus.in_status[3];
                        sat_q      <= 1'b0;
                        small_q    <= 1'b0;
                        dir_left_q <= 1'b0;
                        rem_q      <= 5'd0;
                        // Priority: zero/underflow beats saturation beats range checks
                        if (cls_zero_w) begin
                            mag_q <= 32'd0;
                        end else if (cls_sat_w) begin
                            sat_q <= 1'b1;
                        end else if (cls_small_w) begin
                            mag_q   <= 32'd0;
                            small_q <= 1'b1;
                        end else if (cls_left_w) begin
                            dir_left_q <= 1'b1;
                            rem_q      <= rem_left_w;
                        end else begin
                            rem_q <= rem_right_w;
                        end
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (rem_q != 5'd0) begin
                        mag_q <= dir_left_q ? mag_left_d : mag_right_d;
                        if (!dir_left_q) begin
                            sticky_q <= sticky_q | (|lost_bits);
                        end
                        rem_q <= rem_d;
                    end else begin
                        out_data_q    <= result_d;
                        out_sat_q     <= sat_q;
                        out_inexact_q <= sticky_q | stat_inx_q | small_q;
                        out_valid_q   <= 1'b1;
                        state_q       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = (state_q == ST_IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_sat     = out_sat_q;
    assign bus.out_inexact = out_inexact_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

`default_nettype wire
